// File: rtl/line_word_reader.sv
// line_word_reader: single-line read buffer between the CPU data port and
// physical memory. It serves 16-bit word reads out of one buffered 128-bit
// line, fetches the whole line on a miss, and drops the line when a CPU write
// hits its tag. Hit and miss events are tallied in saturating counters.
module line_word_reader #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      mem_address,
  input  logic             mem_read,
  output logic [15:0]      mem_rdata,
  output logic             mem_resp,
  output logic [15:0]      pmem_address,
  output logic             pmem_read,
  input  logic [127:0]     pmem_rdata,
  input  logic             pmem_resp,
  input  logic             inv_valid,
  input  logic [15:0]      inv_address,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t       state_r;
  logic [127:0] line_q;
  logic [11:0]  tag_q;
  logic         valid_q;
  logic         pend_inv_q;
  logic [2:0]   cur_off_q;

  logic         hit_s;
  logic         inv_old_s;
  logic         inv_fetch_s;
  logic         unused_s;

  // Word n of a line occupies bits [16n+15:16n].
  function automatic logic [15:0] word_sel(input logic [127:0] line, input logic [2:0] off);
    return line[{off, 4'b0000} +: 16];
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign hit_s       = mem_read && valid_q && (mem_address[15:4] == tag_q);
  assign inv_old_s   = inv_valid && (inv_address[15:4] == tag_q);
  // pmem_address holds the in-flight fetch tag for the whole FETCH state.
  assign inv_fetch_s = inv_valid && (inv_address[15:4] == pmem_address[15:4]);
  // Byte-within-word bits of both addresses play no part in tag matching.
  assign unused_s    = ^{inv_address[3:0], mem_address[0]};

  // Read FSM, line buffer, invalidation tracking and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      valid_q      <= 1'b0;
      pend_inv_q   <= 1'b0;
      line_q       <= 128'd0;
      tag_q        <= 12'd0;
      cur_off_q    <= 3'd0;
      mem_resp     <= 1'b0;
      mem_rdata    <= 16'd0;
      pmem_read    <= 1'b0;
      pmem_address <= 16'd0;
      hit_count    <= {CNT_W{1'b0}};
      miss_count   <= {CNT_W{1'b0}};
    end else begin
      // Clear wins over a same-cycle increment.
      if (cnt_clear) begin
        hit_count  <= {CNT_W{1'b0}};
        miss_count <= {CNT_W{1'b0}};
      end else if (state_r == IDLE && mem_read) begin
        if (hit_s) begin
          hit_count <= sat_inc(hit_count);
        end else begin
          miss_count <= sat_inc(miss_count);
        end
      end

      // A write to the buffered line kills it; a fill below overrides this.
      if (inv_old_s) begin
        valid_q <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          mem_resp <= 1'b0;
          if (mem_read) begin
            cur_off_q <= mem_address[3:1];
            if (hit_s) begin
              // line_q is untouched this cycle, so a same-cycle invalidate
              // still lets this hit return the buffered data.
              mem_rdata <= word_sel(line_q, mem_address[3:1]);
              mem_resp  <= 1'b1;
              state_r   <= RESP;
            end else begin
              pmem_address <= {mem_address[15:4], 4'b0000};
              pmem_read    <= 1'b1;
              pend_inv_q   <= 1'b0;
              state_r      <= FETCH;
            end
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            line_q     <= pmem_rdata;
            tag_q      <= pmem_address[15:4];
            // The CPU still gets the filled word, but a write seen during the
            // fetch means the line must not be trusted afterwards.
            valid_q    <= !(pend_inv_q || inv_fetch_s);
            pend_inv_q <= 1'b0;
            pmem_read  <= 1'b0;
            mem_rdata  <= word_sel(pmem_rdata, cur_off_q);
            mem_resp   <= 1'b1;
            state_r    <= RESP;
          end else if (inv_fetch_s) begin
            pend_inv_q <= 1'b1;
          end
        end
        RESP: begin
          mem_resp <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          mem_resp  <= 1'b0;
          pmem_read <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_word_reader.sv
// Bench for line_word_reader: directed vector table, hand-written reset and
// counter sequences, then randomized reads checked against a line-level model.
module tb_line_word_reader;

  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [15:0]      mem_address;
  logic             mem_read;
  logic [15:0]      mem_rdata;
  logic             mem_resp;
  logic [15:0]      pmem_address;
  logic             pmem_read;
  logic [127:0]     pmem_rdata;
  logic             pmem_resp;
  logic             inv_valid;
  logic [15:0]      inv_address;
  logic             cnt_clear;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  line_word_reader #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .inv_valid(inv_valid), .inv_address(inv_address),
    .cnt_clear(cnt_clear), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: is a line buffered, which tag, and the event tallies.
  logic       m_valid;
  logic [11:0] m_tag;
  int         m_hits;
  int         m_misses;

  typedef struct {
    logic        inv_en;
    logic [15:0] inv_addr;
    logic [15:0] addr;
    int          mode;     // 0 plain, 1 inv during fetch, 2 inv with pmem_resp, 3 inv with request
    logic        exp_hit;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [11:0] t);
    logic [127:0] l;
    l = 128'd0;
    if (t == 12'h123) begin
      l = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    end else begin
      for (int n = 0; n < 8; n++) begin
        l[16*n +: 16] = {t, 1'b0, 3'(n)};
      end
    end
    return l;
  endfunction

  function automatic logic [15:0] word_of(input logic [127:0] l, input int off);
    return l[16*off +: 16];
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic inv_write(input logic [15:0] a);
    inv_valid   = 1'b1;
    inv_address = a;
    @(posedge clk); #1;
    inv_valid = 1'b0;
    if (a[15:4] == m_tag) m_valid = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr, input int mode,
                          input logic exp_hit, input logic [15:0] exp_data, input int delay);
    bit got = 0, seen = 0, fetched = 0;
    int cyc = 0, wcnt = 0;
    mem_address = addr;
    mem_read    = 1'b1;
    if (mode == 3) begin
      inv_valid   = 1'b1;
      inv_address = {addr[15:4], 4'h2};
    end
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      pmem_resp = 1'b0;
      inv_valid = 1'b0;
      if (mem_resp) begin
        got = 1;
      end else if (pmem_read && !fetched) begin
        if (!seen) begin
          seen = 1;
          chk("pmem_address", 32'(pmem_address), {16'd0, addr[15:4], 4'h0});
          if (mode == 1) begin
            inv_valid   = 1'b1;
            inv_address = {addr[15:4], 4'h6};
          end
        end
        if (wcnt >= delay) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_line(addr[15:4]);
          fetched    = 1;
          if (mode == 2) begin
            inv_valid   = 1'b1;
            inv_address = {addr[15:4], 4'hA};
          end
        end
        wcnt++;
      end
    end
    mem_read = 1'b0;
    if (!got) begin
      chk("read_timeout", 32'd0, 32'd1);
    end else begin
      chk("rdata", 32'(mem_rdata), 32'(exp_data));
      chk("hit_path", {31'd0, exp_hit ? (cyc == 1 && !seen) : seen}, 32'd1);
    end
    // Model update at transaction level.
    if (exp_hit) begin
      m_hits = sat(m_hits + 1);
      if (mode == 3) m_valid = 1'b0;
    end else begin
      m_misses = sat(m_misses + 1);
      m_tag    = addr[15:4];
      m_valid  = (mode == 0);
    end
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_misses));
    @(posedge clk); #1;
    chk("resp_one_cycle", {31'd0, mem_resp}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; mem_address = 16'd0; mem_read = 1'b0; pmem_rdata = 128'd0;
    pmem_resp = 1'b0; inv_valid = 1'b0; inv_address = 16'd0; cnt_clear = 1'b0;
    m_valid = 1'b0; m_tag = 12'd0; m_hits = 0; m_misses = 0;

    vecs[0]  = '{1'b0, 16'h0000, 16'h1236, 0, 1'b0, 16'h3333};
    vecs[1]  = '{1'b0, 16'h0000, 16'h1230, 0, 1'b1, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0000, 16'h123E, 0, 1'b1, 16'h7777};
    vecs[3]  = '{1'b1, 16'h1234, 16'h1232, 0, 1'b0, 16'h1111};
    vecs[4]  = '{1'b1, 16'h4560, 16'h1238, 0, 1'b1, 16'h4444};
    vecs[5]  = '{1'b1, 16'h1230, 16'h1230, 1, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 16'h0000, 16'h1230, 0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 16'h0000, 16'h123A, 0, 1'b1, 16'h5555};
    vecs[8]  = '{1'b0, 16'h0000, 16'h4562, 2, 1'b0, 16'h4561};
    vecs[9]  = '{1'b0, 16'h0000, 16'h4562, 0, 1'b0, 16'h4561};
    vecs[10] = '{1'b0, 16'h0000, 16'h456E, 0, 1'b1, 16'h4567};
    vecs[11] = '{1'b0, 16'h0000, 16'h4560, 3, 1'b1, 16'h4560};
    vecs[12] = '{1'b0, 16'h0000, 16'h4564, 0, 1'b0, 16'h4562};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
    chk("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("rst_mem_rdata", 32'(mem_rdata), 32'd0);
    chk("rst_pmem_address", 32'(pmem_address), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].inv_en) inv_write(vecs[i].inv_addr);
      cpu_read(vecs[i].addr, vecs[i].mode, vecs[i].exp_hit, vecs[i].exp_data,
               (vecs[i].mode == 1) ? 2 : 0);
    end

    // Reset in the middle of a fetch; the late pmem_resp must be ignored.
    mem_address = 16'h7890; mem_read = 1'b1;
    @(posedge clk); #1;
    chk("midfetch_pmem_read", {31'd0, pmem_read}, 32'd1);
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    chk("rst_fetch_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("rst_fetch_mem_resp", {31'd0, mem_resp}, 32'd0);
    reset = 1'b0; pmem_resp = 1'b1; pmem_rdata = mem_line(12'h789);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk("late_pmem_resp", {31'd0, mem_resp}, 32'd0);
    m_valid = 1'b0; m_hits = 0; m_misses = 0;
    cpu_read(16'h7890, 0, 1'b0, 16'h7890, 1);

    // Randomized reads against the model.
    begin
      logic [11:0] tags [4];
      tags[0] = 12'h123; tags[1] = 12'h456; tags[2] = 12'hABC; tags[3] = 12'h7F0;
      for (int i = 0; i < 150; i++) begin
        logic [11:0] t;
        logic [2:0]  off;
        logic        h;
        int          md;
        t   = tags[$urandom_range(0, 3)];
        off = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) inv_write({tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15))});
        h  = m_valid && (t == m_tag);
        md = h ? (($urandom_range(0, 3) == 0) ? 3 : 0) : $urandom_range(0, 2);
        cpu_read({t, off, 1'($urandom_range(0, 1))}, md, h,
                 word_of(mem_line(t), int'(off)), (md == 1) ? $urandom_range(1, 3) : $urandom_range(0, 3));
      end
    end

    // Saturation: make sure 0x1230 is buffered, then stream MAXC+2 hits.
    if (!(m_valid && m_tag == 12'h123)) cpu_read(16'h1230, 0, 1'b0, 16'h0000, 0);
    mem_address = 16'h1232; mem_read = 1'b1;
    repeat (2 * (MAXC + 2)) @(posedge clk);
    #1;
    mem_read = 1'b0;
    m_hits = sat(m_hits + MAXC + 2);
    chk("hit_saturate", 32'(hit_count), 32'(MAXC));
    chk("miss_after_sat", 32'(miss_count), 32'(m_misses));

    // Clear in the same cycle as a hit: clear wins.
    cnt_clear = 1'b1; mem_read = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0; mem_read = 1'b0;
    chk("clear_hit_resp", {31'd0, mem_resp}, 32'd1);
    chk("clear_hit_count", 32'(hit_count), 32'd0);
    chk("clear_miss_count", 32'(miss_count), 32'd0);
    @(posedge clk); #1;
    m_hits = 0; m_misses = 0;
    cpu_read(16'h123C, 0, 1'b1, 16'h6666, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_word_reader.md
Name: line_word_reader

Overview:
- Read-side counterpart of the cache's word-insert path: a single-line read buffer between the CPU data port and physical memory.
- Serves CPU word reads out of one buffered 128-bit line. On a miss, fetches the whole line over the pmem handshake, then extracts the addressed word.
- Write traffic invalidates the buffered line on a tag match.
- Sits on the read path beside the write/insert logic; carries hit/miss performance counters.

Parameters:
- CNT_W, 16, width of the hit and miss performance counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- mem_address  input  16  CPU byte address; tag = [15:4], word offset = [3:1], bit 0 ignored
- mem_read  input  1  CPU read request; held high by the CPU until mem_resp
- mem_rdata  output  16  selected word (lc3b_word); valid only while mem_resp=1
- mem_resp  output  1  one-cycle read completion
- pmem_address  output  16  line address {tag,4'b0000}
- pmem_read  output  1  line fetch request; held until pmem_resp
- pmem_rdata  input  128  fetched line (lc3b_line)
- pmem_resp  input  1  fetch completion, one cycle
- inv_valid  input  1  a CPU write occurs this cycle
- inv_address  input  16  address of that write
- cnt_clear  input  1  synchronous clear of both counters
- hit_count  output  CNT_W  saturating count of read hits
- miss_count  output  CNT_W  saturating count of read misses

Behaviour:
- Internal state:
  - line_q[127:0], tag_q[11:0], valid_q, pend_inv_q, cur_off_q[2:0].
  - FSM states: IDLE, FETCH, RESP.
- Reset (synchronous, overrides everything):
  - state=IDLE; valid_q=0; pend_inv_q=0.
  - mem_resp=0, pmem_read=0, mem_rdata=0, pmem_address=0, hit_count=0, miss_count=0.
  - Reset in FETCH drops pmem_read on the next edge. A pmem_resp arriving later in IDLE is ignored.
- Word select: word n = line_q[16n+15:16n], n = offset. Offset 0 → [15:0]; offset 7 → [127:112]. Full word is always returned; byte selection belongs to the datapath.
- IDLE:
  - Hit: mem_read=1, valid_q=1 and mem_address[15:4]==tag_q. Latch the offset, go to RESP, hit_count++.
  - Miss: latch the offset, drive pmem_address={mem_address[15:4],4'b0}, go to FETCH, miss_count++.
  - Hit latency: request sampled at edge k; mem_resp high in cycle k+1.
- FETCH:
  - pmem_read=1; pmem_address held stable.
  - On pmem_resp: line_q←pmem_rdata; tag_q←fetch tag; valid_q←!pend_inv_q; clear pend_inv_q; go to RESP.
- RESP:
  - mem_resp=1 for exactly one cycle; mem_rdata = selected word of line_q.
  - Next state is IDLE unconditionally. A request is re-sampled only in IDLE, so there are no duplicate responses.
- Invalidate (any state):
  - inv_valid with inv_address[15:4]==tag_q clears valid_q.
  - In FETCH, inv_valid matching the in-flight fetch tag sets pend_inv_q. The filled data is still returned to the CPU, but the line is not marked valid.
  - inv_valid in the same cycle as pmem_resp for the same tag: line not marked valid.
  - A non-matching inv_valid has no effect.
- Invalidate and hit in the same cycle for the same tag: the hit is served (line_q is unchanged this cycle) and valid_q clears afterwards.
- Counters:
  - Increment by 1, saturate at all-ones (no wrap).
  - cnt_clear has priority over an increment in the same cycle.
- mem_address must be stable while mem_read is high; it is not re-sampled in FETCH or RESP.

Test Plan:
- Cold miss: after reset, read 0x1236 → pmem_read high with pmem_address=0x1230. Return pmem_rdata = 0x7777_6666_5555_4444_3333_2222_1111_0000 → mem_resp one cycle later with mem_rdata=0x3333; miss_count=1.
- Hit, offsets 0 and 7: read 0x1230 → mem_rdata=0x0000 one cycle after request, no pmem_read. Read 0x123E → 0x7777; hit_count=2.
- Invalidate: inv_valid with inv_address=0x1234, then read 0x1232 → miss and refetch. inv_valid with inv_address=0x4560 → next 0x123x read still hits.
- Invalidate during fetch: inv to 0x1230 while in FETCH for 0x1230 → the CPU still gets the fetched word. The immediate re-read of 0x1230 misses again.
- Reset mid-fetch: assert reset in FETCH → pmem_read=0 and mem_resp=0 next cycle. A late pmem_resp is ignored; the next read of the same address misses.
- Counter saturation and clear: force 0xFFFF+2 hits → hit_count stays 0xFFFF. cnt_clear together with a hit → hit_count=0.
